pe_driver: RTL and testbench
============================

// Module: pe_driver
// PURPOSE
//  Initiator side of the PE instruction and FIFO interfaces: takes one job descriptor, issues its
//  opcode/conv_info to the PE, streams exactly the programmed number of ifmap/wght/psum_in words
//  from global-buffer sources into the PE, and drains the programmed psum_out words to a GB sink.
//  Sits between the global buffer and one PE; one job in flight at a time.
// PARAMETERS
//  IFMAP_BUS_BITWIDTH  8   ifmap word width (PE ifmap FIFO bus)
//  WGHT_BUS_BITWIDTH   32  weight word width
//  PSUM_BUS_BITWIDTH   32  psum in/out word width
//  CNT_BITWIDTH        10  width of every per-job word counter (max 2^CNT_BITWIDTH-1 words/channel)
// PORTS
//  i_clk                 in   1    clock
//  i_rst                 in   1    reset, synchronous, active-high
//  i_job_valid           in   1    job descriptor valid
//  o_job_ready           out  1    job accepted when valid&ready
//  i_job_opcode          in   3    opcode forwarded to PE
//  i_job_conv_info       in   11   {p[3:0],q[2:0],s[3:0]} forwarded to PE
//  i_job_ifmap_cnt       in   CNT  ifmap words to send
//  i_job_wght_cnt        in   CNT  weight words to send
//  i_job_psum_in_cnt     in   CNT  psum words to send
//  i_job_psum_out_cnt    in   CNT  psum words to collect
//  i_gb_{ifmap,wght,psum}_data/valid in, o_gb_{ifmap,wght,psum}_ready out  source streams (bus widths)
//  o_inst_data           out  3    PE opcode;  o_conv_info out 11 PE conv info
//  o_inst_valid          out  1    instruction valid;  i_inst_ready in 1 PE ready/idle
//  o_ifmap_fifo_data/valid out, i_ifmap_fifo_ready in    to PE ifmap FIFO
//  o_wght_fifo_data/valid out, i_wght_fifo_ready in      to PE weight FIFO
//  o_psum_in_fifo_data/valid out, i_psum_in_fifo_ready in to PE psum_in FIFO
//  i_psum_out_fifo_data/valid in, o_psum_out_fifo_ready out from PE psum_out FIFO
//  o_gb_out_data/valid out, i_gb_out_ready in            psum sink toward GB
//  o_busy out 1  state!=IDLE;   o_done out 1  one-cycle pulse at job completion
// BEHAVIOUR
//  - Reset (sync): state IDLE, all counters 0, all o_*valid/o_*ready 0 except o_job_ready=1 the
//    cycle after reset deasserts; o_done=0, o_busy=0, o_inst_data/o_conv_info=0. Mid-job reset
//    abandons the job; no valid/ready asserted the cycle after i_rst is sampled.
//  - FSM: IDLE -> ISSUE -> STREAM -> WAIT_PE -> IDLE.
//    IDLE: o_job_ready=1; on job handshake latch opcode, conv_info, four counts; go ISSUE.
//    ISSUE: o_inst_valid=1 with latched opcode/conv_info held stable until i_inst_ready; on
//      handshake go STREAM. No stream handshake occurs in ISSUE.
//    STREAM: per channel, dst_valid = src_valid & (rem!=0); src_ready = dst_ready & (rem!=0);
//      data passes combinationally; rem decrements on each handshake. All four channels run
//      concurrently and independently. When all rem==0 go WAIT_PE (zero-count channels are
//      complete at entry; all-zero job goes to WAIT_PE after one STREAM cycle).
//    WAIT_PE: wait for i_inst_ready=1 (PE idle); then o_done=1 for that one cycle, go IDLE.
//  - Counter never underflows; after rem hits 0 that channel holds valid/ready low, so extra source
//    words stay in the GB FIFO and excess PE psum_out words are not consumed.
//  - Latency: job handshake -> o_inst_valid next cycle; inst handshake -> stream ready next cycle.
//  - Job inputs ignored outside IDLE; o_job_ready=0 there. Back-to-back jobs: new job accepted the
//    cycle after o_done (IDLE).
// STRUCTURE
//  - pe_pkg: opcode localparams, FSM state enum (IDLE/ISSUE/STREAM/WAIT_PE), conv_info field offsets.
//  - Sub-module pe_stream_gate #(DATA_W, CNT_W): load/count/gate one valid-ready channel, exposes
//    o_zero; instantiated four times (ifmap, wght, psum_in, psum_out->GB).
// TESTING
//  - Job op=3'b001, info=11'h2A5, counts 4/2/1/1, all ready -> o_inst_valid 1 cycle later with
//    0x2A5; exactly 4/2/1 words forwarded, 1 psum collected, o_done one pulse.
//  - i_inst_ready low 5 cycles in ISSUE -> o_inst_valid and o_conv_info stable, no stream traffic.
//  - Random valid/ready stalls, counts 17/9/3/3 -> word-exact, in-order forwarding; 18th ifmap source
//    word not consumed (o_gb_ifmap_ready=0 once rem=0).
//  - Counts all 0 -> ISSUE, STREAM 1 cycle, WAIT_PE until i_inst_ready, o_done; no data handshakes.
//  - i_rst asserted mid-STREAM with rem=5 -> next cycle all valids/readys 0, o_busy 0, o_job_ready 1.
//  - Two jobs back-to-back -> second accepted cycle after first o_done; counters reloaded correctly.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE driver.
// One job descriptor drives a single PE through issue, stream and drain.
package pe_pkg;

   localparam int IFMAP_W = 8;
   localparam int WGHT_W  = 32;
   localparam int PSUM_W  = 32;
   localparam int CNT_W   = 10;
   localparam int OP_W    = 3;
   localparam int INFO_W  = 11;

   localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
   localparam logic [OP_W-1:0] OP_CONV = 3'b001;

   // conv_info packs {p[3:0], q[2:0], s[3:0]}
   localparam int INFO_S_LSB = 0;
   localparam int INFO_Q_LSB = 4;
   localparam int INFO_P_LSB = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_STREAM,
      ST_WAIT_PE
   } pe_state_e;

endpackage

// File: rtl/pe_driver_if.sv
// Job, instruction and FIFO handshake bundle between GB, driver and PE.
// master is the driver view, slave is the surrounding GB/PE view.
interface pe_driver_if #(
   parameter int IFMAP_W = 8,
   parameter int WGHT_W  = 32,
   parameter int PSUM_W  = 32,
   parameter int CNT_W   = 10
);
   logic               i_job_valid;
   logic               o_job_ready;
   logic [2:0]         i_job_opcode;
   logic [10:0]        i_job_conv_info;
   logic [CNT_W-1:0]   i_job_ifmap_cnt;
   logic [CNT_W-1:0]   i_job_wght_cnt;
   logic [CNT_W-1:0]   i_job_psum_in_cnt;
   logic [CNT_W-1:0]   i_job_psum_out_cnt;

   logic [IFMAP_W-1:0] i_gb_ifmap_data;
   logic               i_gb_ifmap_valid;
   logic               o_gb_ifmap_ready;
   logic [WGHT_W-1:0]  i_gb_wght_data;
   logic               i_gb_wght_valid;
   logic               o_gb_wght_ready;
   logic [PSUM_W-1:0]  i_gb_psum_data;
   logic               i_gb_psum_valid;
   logic               o_gb_psum_ready;

   logic [2:0]         o_inst_data;
   logic [10:0]        o_conv_info;
   logic               o_inst_valid;
   logic               i_inst_ready;

   logic [IFMAP_W-1:0] o_ifmap_fifo_data;
   logic               o_ifmap_fifo_valid;
   logic               i_ifmap_fifo_ready;
   logic [WGHT_W-1:0]  o_wght_fifo_data;
   logic               o_wght_fifo_valid;
   logic               i_wght_fifo_ready;
   logic [PSUM_W-1:0]  o_psum_in_fifo_data;
   logic               o_psum_in_fifo_valid;
   logic               i_psum_in_fifo_ready;
   logic [PSUM_W-1:0]  i_psum_out_fifo_data;
   logic               i_psum_out_fifo_valid;
   logic               o_psum_out_fifo_ready;

   logic [PSUM_W-1:0]  o_gb_out_data;
   logic               o_gb_out_valid;
   logic               i_gb_out_ready;

   logic               o_busy;
   logic               o_done;

   modport master (
      input  i_job_valid, i_job_opcode, i_job_conv_info,
      input  i_job_ifmap_cnt, i_job_wght_cnt,
      input  i_job_psum_in_cnt, i_job_psum_out_cnt,
      input  i_gb_ifmap_data, i_gb_ifmap_valid,
      input  i_gb_wght_data, i_gb_wght_valid,
      input  i_gb_psum_data, i_gb_psum_valid,
      input  i_inst_ready,
      input  i_ifmap_fifo_ready, i_wght_fifo_ready,
      input  i_psum_in_fifo_ready,
      input  i_psum_out_fifo_data, i_psum_out_fifo_valid,
      input  i_gb_out_ready,
      output o_job_ready,
      output o_gb_ifmap_ready, o_gb_wght_ready, o_gb_psum_ready,
      output o_inst_data, o_conv_info, o_inst_valid,
      output o_ifmap_fifo_data, o_ifmap_fifo_valid,
      output o_wght_fifo_data, o_wght_fifo_valid,
      output o_psum_in_fifo_data, o_psum_in_fifo_valid,
      output o_psum_out_fifo_ready,
      output o_gb_out_data, o_gb_out_valid,
      output o_busy, o_done
   );

   modport slave (
      output i_job_valid, i_job_opcode, i_job_conv_info,
      output i_job_ifmap_cnt, i_job_wght_cnt,
      output i_job_psum_in_cnt, i_job_psum_out_cnt,
      output i_gb_ifmap_data, i_gb_ifmap_valid,
      output i_gb_wght_data, i_gb_wght_valid,
      output i_gb_psum_data, i_gb_psum_valid,
      output i_inst_ready,
      output i_ifmap_fifo_ready, i_wght_fifo_ready,
      output i_psum_in_fifo_ready,
      output i_psum_out_fifo_data, i_psum_out_fifo_valid,
      output i_gb_out_ready,
      input  o_job_ready,
      input  o_gb_ifmap_ready, o_gb_wght_ready, o_gb_psum_ready,
      input  o_inst_data, o_conv_info, o_inst_valid,
      input  o_ifmap_fifo_data, o_ifmap_fifo_valid,
      input  o_wght_fifo_data, o_wght_fifo_valid,
      input  o_psum_in_fifo_data, o_psum_in_fifo_valid,
      input  o_psum_out_fifo_ready,
      input  o_gb_out_data, o_gb_out_valid,
      input  o_busy, o_done
   );

endinterface

// File: rtl/pe_stream_gate.sv
// One counted valid/ready channel: passes exactly the loaded number of words.
// Once the count is exhausted both valid and ready are held low.
module pe_stream_gate #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [CNT_W-1:0]  load_cnt,
   input  logic              en,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ready,
   output logic              dst_valid,
   output logic [DATA_W-1:0] dst_data,
   input  logic              dst_ready,
   output logic              o_zero
);

   logic [CNT_W-1:0] rem_q;
   logic             live;

   assign o_zero    = (rem_q == '0);
   assign live      = en & ~o_zero;
   assign dst_valid = live & src_valid;
   assign src_ready = live & dst_ready;
   assign dst_data  = src_data;

   always_ff @(posedge clk) begin
      if (rst)
         rem_q <= '0;
      else if (load)
         rem_q <= load_cnt;
      else if (live & src_valid & dst_ready)
         rem_q <= rem_q - 1'b1;
   end

endmodule

// File: rtl/pe_driver.sv
// PE initiator: accepts a job, issues the instruction, streams and drains
// the programmed word counts, then waits for the PE to go idle.
module pe_driver
   import pe_pkg::*;
#(
   parameter int IFMAP_BUS_BITWIDTH = 8,
   parameter int WGHT_BUS_BITWIDTH  = 32,
   parameter int PSUM_BUS_BITWIDTH  = 32,
   parameter int CNT_BITWIDTH       = 10
) (
   input logic          i_clk,
   input logic          i_rst,
   pe_driver_if.master  bus
);

   pe_state_e   state_q, state_d;
   logic [2:0]  op_q;
   logic [10:0] info_q;
   logic        load, en;
   logic [3:0]  zero;

   assign load = (state_q == ST_IDLE) & bus.i_job_valid;
   assign en   = (state_q == ST_STREAM);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         info_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            op_q   <= bus.i_job_opcode;
            info_q <= bus.i_job_conv_info;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      bus.o_job_ready  = 1'b0;
      bus.o_inst_valid = 1'b0;
      bus.o_done       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            bus.o_job_ready = 1'b1;
            if (bus.i_job_valid) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            bus.o_inst_valid = 1'b1;
            if (bus.i_inst_ready) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (&zero) state_d = ST_WAIT_PE;
         end
         ST_WAIT_PE: begin
            // PE reports idle through the same ready line
            if (bus.i_inst_ready) begin
               bus.o_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.o_inst_data = op_q;
   assign bus.o_conv_info = info_q;
   assign bus.o_busy      = (state_q != ST_IDLE);

   pe_stream_gate #(.DATA_W(IFMAP_BUS_BITWIDTH), .CNT_W(CNT_BITWIDTH)) u_ifmap (
      .clk(i_clk), .rst(i_rst), .load(load),
      .load_cnt(bus.i_job_ifmap_cnt), .en(en),
      .src_valid(bus.i_gb_ifmap_valid), .src_data(bus.i_gb_ifmap_data),
      .src_ready(bus.o_gb_ifmap_ready),
      .dst_valid(bus.o_ifmap_fifo_valid), .dst_data(bus.o_ifmap_fifo_data),
      .dst_ready(bus.i_ifmap_fifo_ready), .o_zero(zero[0])
   );

   pe_stream_gate #(.DATA_W(WGHT_BUS_BITWIDTH), .CNT_W(CNT_BITWIDTH)) u_wght (
      .clk(i_clk), .rst(i_rst), .load(load),
      .load_cnt(bus.i_job_wght_cnt), .en(en),
      .src_valid(bus.i_gb_wght_valid), .src_data(bus.i_gb_wght_data),
      .src_ready(bus.o_gb_wght_ready),
      .dst_valid(bus.o_wght_fifo_valid), .dst_data(bus.o_wght_fifo_data),
      .dst_ready(bus.i_wght_fifo_ready), .o_zero(zero[1])
   );

   pe_stream_gate #(.DATA_W(PSUM_BUS_BITWIDTH), .CNT_W(CNT_BITWIDTH)) u_psum_in (
      .clk(i_clk), .rst(i_rst), .load(load),
      .load_cnt(bus.i_job_psum_in_cnt), .en(en),
      .src_valid(bus.i_gb_psum_valid), .src_data(bus.i_gb_psum_data),
      .src_ready(bus.o_gb_psum_ready),
      .dst_valid(bus.o_psum_in_fifo_valid), .dst_data(bus.o_psum_in_fifo_data),
      .dst_ready(bus.i_psum_in_fifo_ready), .o_zero(zero[2])
   );

   pe_stream_gate #(.DATA_W(PSUM_BUS_BITWIDTH), .CNT_W(CNT_BITWIDTH)) u_psum_out (
      .clk(i_clk), .rst(i_rst), .load(load),
      .load_cnt(bus.i_job_psum_out_cnt), .en(en),
      .src_valid(bus.i_psum_out_fifo_valid), .src_data(bus.i_psum_out_fifo_data),
      .src_ready(bus.o_psum_out_fifo_ready),
      .dst_valid(bus.o_gb_out_valid), .dst_data(bus.o_gb_out_data),
      .dst_ready(bus.i_gb_out_ready), .o_zero(zero[3])
   );

endmodule

// File: tb/tb_pe_driver.sv
// Directed bench for pe_driver: job issue, counted streaming,
// stalls, zero-count jobs, mid-job reset and back-to-back jobs.
module tb_pe_driver;
   import pe_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   pe_driver_if bus ();

   pe_driver dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int seed, input int ch,
                                       input int idx);
      return 32'(seed * 4096 + ch * 256 + idx);
   endfunction

   task automatic set_idle();
      bus.i_job_valid           = 1'b0;
      bus.i_gb_ifmap_valid      = 1'b0;
      bus.i_gb_wght_valid       = 1'b0;
      bus.i_gb_psum_valid       = 1'b0;
      bus.i_psum_out_fifo_valid = 1'b0;
      bus.i_ifmap_fifo_ready    = 1'b0;
      bus.i_wght_fifo_ready     = 1'b0;
      bus.i_psum_in_fifo_ready  = 1'b0;
      bus.i_gb_out_ready        = 1'b0;
      bus.i_inst_ready          = 1'b0;
   endtask

   function automatic logic pick(input bit stall);
      return stall ? ($urandom_range(0, 3) != 0) : 1'b1;
   endfunction

   task automatic run_job(
      input logic [2:0]  op,
      input logic [10:0] info,
      input int ci, input int cw, input int cp, input int co,
      input bit stall, input int hold, input int gap,
      input int abort_k, input int tail, input int exp_done,
      input int seed
   );
      int ni = 0, nw = 0, np = 0, no = 0;
      int si = 0, sw = 0, sp = 0, so = 0;
      int ndone = 0, done_k = -1, iss_x = 0;
      bit aborted = 1'b0;
      bit any;
      @(negedge clk);
      chk("job_ready", bus.o_job_ready, 1);
      set_idle();
      bus.i_job_valid        = 1'b1;
      bus.i_job_opcode       = op;
      bus.i_job_conv_info    = info;
      bus.i_job_ifmap_cnt    = 10'(ci);
      bus.i_job_wght_cnt     = 10'(cw);
      bus.i_job_psum_in_cnt  = 10'(cp);
      bus.i_job_psum_out_cnt = 10'(co);
      @(negedge clk);
      for (int k = 0; k < 600; k++) begin
         bus.i_job_valid        = 1'b0;
         bus.i_job_opcode       = ~op;
         bus.i_job_conv_info    = ~info;
         bus.i_job_ifmap_cnt    = '1;
         bus.i_job_wght_cnt     = '1;
         bus.i_job_psum_in_cnt  = '1;
         bus.i_job_psum_out_cnt = '1;
         if (k == 0)
            chk("inst_lat", {bus.o_inst_valid, bus.o_inst_data, bus.o_conv_info},
                {1'b1, op, info});
         else if (k < hold)
            chk("issue_hold", {bus.o_inst_valid, bus.o_inst_data, bus.o_conv_info},
                {1'b1, op, info});
         bus.i_gb_ifmap_valid      = pick(stall);
         bus.i_gb_ifmap_data       = 8'(pat(seed, 0, ni));
         bus.i_gb_wght_valid       = pick(stall);
         bus.i_gb_wght_data        = pat(seed, 1, nw);
         bus.i_gb_psum_valid       = pick(stall);
         bus.i_gb_psum_data        = pat(seed, 2, np);
         bus.i_psum_out_fifo_valid = pick(stall);
         bus.i_psum_out_fifo_data  = pat(seed, 3, no);
         bus.i_ifmap_fifo_ready    = pick(stall);
         bus.i_wght_fifo_ready     = pick(stall);
         bus.i_psum_in_fifo_ready  = pick(stall);
         bus.i_gb_out_ready        = pick(stall);
         bus.i_inst_ready = (k < hold) ? 1'b0 :
                            (k > hold && k <= hold + gap) ? 1'b0 : 1'b1;
         if (k == abort_k) begin
            aborted = 1'b1;
            rst     = 1'b1;
            break;
         end
         #1;
         any = 1'b0;
         if (bus.o_ifmap_fifo_valid && bus.i_ifmap_fifo_ready) begin
            chk("ifmap_data", bus.o_ifmap_fifo_data, 8'(pat(seed, 0, ni)));
            ni++; any = 1'b1;
         end
         if (bus.o_wght_fifo_valid && bus.i_wght_fifo_ready) begin
            chk("wght_data", bus.o_wght_fifo_data, pat(seed, 1, nw));
            nw++; any = 1'b1;
         end
         if (bus.o_psum_in_fifo_valid && bus.i_psum_in_fifo_ready) begin
            chk("psum_in_data", bus.o_psum_in_fifo_data, pat(seed, 2, np));
            np++; any = 1'b1;
         end
         if (bus.o_gb_out_valid && bus.i_gb_out_ready) begin
            chk("gb_out_data", bus.o_gb_out_data, pat(seed, 3, no));
            no++; any = 1'b1;
         end
         if (bus.i_gb_ifmap_valid && bus.o_gb_ifmap_ready) si++;
         if (bus.i_gb_wght_valid && bus.o_gb_wght_ready) sw++;
         if (bus.i_gb_psum_valid && bus.o_gb_psum_ready) sp++;
         if (bus.i_psum_out_fifo_valid && bus.o_psum_out_fifo_ready) so++;
         if (any && bus.o_inst_valid) iss_x++;
         if (bus.o_done) begin
            ndone++;
            done_k = k;
         end
         if (ndone > 0 && k >= done_k + tail) break;
         @(negedge clk);
      end
      if (aborted) begin
         chk("pre_abort_ifmap", ni, ci - 5);
         @(negedge clk);
         chk("rst_outs",
             {bus.o_inst_valid, bus.o_ifmap_fifo_valid, bus.o_wght_fifo_valid,
              bus.o_psum_in_fifo_valid, bus.o_gb_out_valid,
              bus.o_gb_ifmap_ready, bus.o_gb_wght_ready, bus.o_gb_psum_ready,
              bus.o_psum_out_fifo_ready, bus.o_done}, 0);
         chk("rst_idle", {bus.o_busy, bus.o_job_ready}, 2'b01);
         rst = 1'b0;
         set_idle();
         return;
      end
      if (ndone == 0) chk("done_timeout", 0, 1);
      chk("ifmap_cnt", ni, ci);
      chk("wght_cnt", nw, cw);
      chk("psum_in_cnt", np, cp);
      chk("psum_out_cnt", no, co);
      chk("src_cnts", {16'(si), 16'(sw), 16'(sp), 16'(so)},
          {16'(ci), 16'(cw), 16'(cp), 16'(co)});
      chk("done_cnt", ndone, 1);
      chk("issue_xfer", iss_x, 0);
      if (exp_done >= 0) chk("done_cyc", done_k, exp_done);
      if (tail > 0)
         chk("post_idle", {bus.o_busy, bus.o_job_ready,
                           bus.o_gb_ifmap_ready, bus.o_psum_out_fifo_ready},
             4'b0100);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      set_idle();
      bus.i_job_opcode       = '0;
      bus.i_job_conv_info    = '0;
      bus.i_job_ifmap_cnt    = '0;
      bus.i_job_wght_cnt     = '0;
      bus.i_job_psum_in_cnt  = '0;
      bus.i_job_psum_out_cnt = '0;
      bus.i_gb_ifmap_data      = '0;
      bus.i_gb_wght_data       = '0;
      bus.i_gb_psum_data       = '0;
      bus.i_psum_out_fifo_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {bus.o_job_ready, bus.o_busy, bus.o_done}, 3'b100);
      chk("rst_inst", {bus.o_inst_valid, bus.o_inst_data, bus.o_conv_info}, 0);
      chk("rst_valids",
          {bus.o_ifmap_fifo_valid, bus.o_wght_fifo_valid,
           bus.o_psum_in_fifo_valid, bus.o_gb_out_valid,
           bus.o_psum_out_fifo_ready}, 0);

      run_job(OP_CONV, 11'h2A5, 4, 2, 1, 1, 1'b0, 0, 0, -1, 2, 6, 1);
      run_job(3'b010, 11'h5C3, 3, 2, 2, 1, 1'b0, 5, 0, -1, 2, 10, 2);
      run_job(3'b011, 11'h13F, 17, 9, 3, 3, 1'b1, 0, 0, -1, 2, -1, 3);
      run_job(3'b100, 11'h7FF, 0, 0, 0, 0, 1'b0, 2, 4, -1, 2, 7, 4);
      run_job(OP_CONV, 11'h0AA, 9, 9, 9, 9, 1'b0, 0, 0, 5, 0, -1, 5);
      run_job(3'b101, 11'h111, 2, 1, 1, 1, 1'b0, 0, 0, -1, 0, 4, 6);
      run_job(3'b110, 11'h222, 3, 3, 2, 2, 1'b0, 0, 0, -1, 2, 5, 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
